// File: rtl/lane_gather_buffer_if.sv
// lane_gather_buffer_if: word stream in (in_valid/in_ready/in/flush), block out (out_valid/out_ready/out/out_lanes)
interface lane_gather_buffer_if #(
  parameter int WORD_WIDTH  = 36,
  parameter int LANES       = 8,
  parameter int COUNT_WIDTH = 4
);
  logic                        in_valid;
  logic                        in_ready;
  logic [WORD_WIDTH-1:0]       in;
  logic                        flush;
  logic                        out_valid;
  logic                        out_ready;
  logic [WORD_WIDTH*LANES-1:0] out;
  logic [COUNT_WIDTH-1:0]      out_lanes;
  modport master (output in_valid, in, flush, out_ready, input in_ready, out_valid, out, out_lanes);
  modport slave  (input in_valid, in, flush, out_ready, output in_ready, out_valid, out, out_lanes);
endinterface

// File: rtl/lane_gather_buffer.sv
// lane_gather_buffer: packs LANES words into a block held in a valid/ready register; ports clock, clear, bus (slave)
module lane_gather_buffer #(
  parameter int WORD_WIDTH  = 36,
  parameter int LANES       = 8,
  parameter int COUNT_WIDTH = 4
) (
  input logic                 clock,
  input logic                 clear,
  lane_gather_buffer_if.slave bus
);
  localparam int IW = LANES > 1 ? $clog2(LANES) : 1;
  localparam logic [COUNT_WIDTH-1:0] FULL = COUNT_WIDTH'(LANES);
  logic [LANES-1:0][WORD_WIDTH-1:0] gather_q, gather_d, gather_acc, out_q, out_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, cnt_acc, out_lanes_q, out_lanes_d;
  logic pend_q, pend_d, out_valid_q, out_valid_d;
  logic acc, hold_free, drain, complete;
  assign bus.in_ready  = (cnt_q < FULL) && !pend_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.out_lanes = out_lanes_q;
  assign acc       = bus.in_valid && bus.in_ready;
  assign hold_free = !out_valid_q || bus.out_ready;
  assign drain     = out_valid_q && bus.out_ready;
  always_comb begin
    gather_acc = gather_q;
    if (acc) gather_acc[cnt_q[IW-1:0]] = bus.in;
    cnt_acc     = cnt_q + COUNT_WIDTH'(acc);
    complete    = (cnt_acc == FULL) || pend_q || (bus.flush && cnt_acc != '0);
    gather_d    = gather_acc;
    cnt_d       = cnt_acc;
    pend_d      = pend_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_d       = drain ? '0 : out_q;
    out_lanes_d = drain ? '0 : out_lanes_q;
    if (complete && hold_free) begin
      gather_d    = '0;
      cnt_d       = '0;
      pend_d      = 1'b0;
      out_valid_d = 1'b1;
      out_d       = gather_acc;
      out_lanes_d = cnt_acc;
    end else if (complete) begin
      pend_d = pend_q || bus.flush;
    end
  end
  always_ff @(posedge clock) begin
    if (clear) begin
      gather_q    <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_lanes_q <= '0;
    end else begin
      gather_q    <= gather_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_lanes_q <= out_lanes_d;
    end
  end
endmodule
